// File: rtl/udp_src_arbiter_pkg.sv
// Shared definitions for the two-source UDP payload arbiter:
// FSM encoding, read-data mux selects, counter width and tag byte layout.
package udp_src_arbiter_pkg;

    localparam int SEQ_W = 7;
    localparam int CNT_W = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TAG   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_TAG  = 2'd1;
    localparam logic [1:0] SEL_SRC0 = 2'd2;
    localparam logic [1:0] SEL_SRC1 = 2'd3;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef struct packed {
        logic gid;
        seq_t seq;
    } tag_t;

    function automatic logic [7:0] make_tag(input logic gid, input seq_t seq);
        tag_t t;
        t.gid = gid;
        t.seq = seq;
        return t;
    endfunction

endpackage

// File: rtl/udp_src_arbiter_if.sv
// Bus between the arbiter, its two source FIFOs and the UDP sender.
// master = arbiter side, slave = FIFOs plus sender side.
interface udp_src_arbiter_if;
    import udp_src_arbiter_pkg::*;

    logic [7:0]       src0_data;
    logic             src0_rd_en;
    logic [CNT_W-1:0] src0_rnum;
    logic [7:0]       src1_data;
    logic             src1_rd_en;
    logic [CNT_W-1:0] src1_rnum;
    logic [7:0]       rd_data;
    logic             rd_en;
    logic [CNT_W-1:0] Rnum;
    logic             busy;

    modport master (
        input  src0_data, src0_rnum, src1_data, src1_rnum, rd_en,
        output src0_rd_en, src1_rd_en, rd_data, Rnum, busy
    );

    modport slave (
        output src0_data, src0_rnum, src1_data, src1_rnum, rd_en,
        input  src0_rd_en, src1_rd_en, rd_data, Rnum, busy
    );

endinterface

// File: rtl/udp_src_arbiter_rr_pick.sv
// Two-way round-robin select: combinational, zero latency, no backpressure.
// With both requesters eligible the pointer decides; otherwise the single eligible one wins.
module udp_rr_pick (
    input  logic [1:0] elig,
    input  logic       ptr,
    output logic       vld,
    output logic       pick
);

    assign vld  = |elig;
    assign pick = (elig == 2'b11) ? ptr : elig[1];

endmodule

// File: rtl/udp_src_arbiter.sv
// Grants one of two byte FIFOs per UDP payload, prefixing a {source, sequence} tag byte.
// rd_data follows rd_en by one cycle; the sender paces reads via rd_en against the advertised Rnum.
module udp_src_arbiter
    import udp_src_arbiter_pkg::*;
#(
    parameter logic [15:0] DATA_SIZE = 16'd961
) (
    input  logic              clk,
    input  logic              rst,
    udp_src_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] PKT_LEN  = DATA_SIZE[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_CNT = PKT_LEN - 11'd1;
    localparam logic [15:0]      ELIG_MIN = DATA_SIZE - 16'd1;

    logic [1:0]       state_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant_q;
    logic             ptr_q;
    seq_t             seq0_q;
    seq_t             seq1_q;

    logic [1:0] elig;
    logic       pick_vld;
    logic       pick_id;
    logic       active;
    logic       rd_take;
    logic       fwd;

    // Eligibility only matters in IDLE; the grant is held for the whole packet.
    assign elig[0] = {5'd0, bus.src0_rnum} >= ELIG_MIN;
    assign elig[1] = {5'd0, bus.src1_rnum} >= ELIG_MIN;

    udp_rr_pick u_pick (
        .elig (elig),
        .ptr  (ptr_q),
        .vld  (pick_vld),
        .pick (pick_id)
    );

    assign active  = (state_q == ST_TAG) || (state_q == ST_DATA);
    assign rd_take = bus.rd_en && active && !rst;
    assign fwd     = rd_take && (state_q == ST_DATA);

    assign bus.src0_rd_en = fwd && !grant_q;
    assign bus.src1_rd_en = fwd && grant_q;
    assign bus.busy       = active && !rst;
    assign bus.Rnum       = (active && !rst) ? (PKT_LEN - cnt_q) : '0;

    // sel_q is captured with the read strobe so the tag and FIFO bytes line up one cycle later.
    always_comb begin
        bus.rd_data = 8'h00;
        if (!rst) begin
            case (sel_q)
                SEL_TAG:  bus.rd_data = make_tag(grant_q, grant_q ? seq1_q : seq0_q);
                SEL_SRC0: bus.rd_data = bus.src0_data;
                SEL_SRC1: bus.rd_data = bus.src1_data;
                default:  bus.rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            seq0_q  <= '0;
            seq1_q  <= '0;
        end else begin
            sel_q <= SEL_NONE;
            if (rd_take) begin
                sel_q <= (state_q == ST_TAG) ? SEL_TAG : (grant_q ? SEL_SRC1 : SEL_SRC0);
                cnt_q <= cnt_q + 11'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_id;
                        cnt_q   <= '0;
                        state_q <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    if (rd_take) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (rd_take && cnt_q == LAST_CNT) state_q <= ST_DRAIN;
                end
                default: begin
                    if (grant_q) seq1_q <= seq1_q + 1'b1;
                    else         seq0_q <= seq0_q + 1'b1;
                    ptr_q   <= ~grant_q;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_src_arbiter.sv
// Bench for udp_src_arbiter: full-size instance with byte scoreboard, plus a minimum-size
// instance used only to run 129 back-to-back packets for the sequence wrap.
module tb_udp_src_arbiter;

    localparam int DS  = 961;
    localparam int DSB = 46;

    typedef struct packed {
        logic       is_tag;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_src_arbiter_if bus_a ();
    udp_src_arbiter_if bus_b ();

    udp_src_arbiter #(.DATA_SIZE(16'(DS))) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    udp_src_arbiter #(.DATA_SIZE(16'(DSB))) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       rd_exp;
    logic [7:0] last_tag;
    logic [6:0] seq_m [2];
    int idx0 = 0, idx1 = 0;
    int base0, base1, mark0, mark1;

    function automatic logic [7:0] src_byte(input int s, input int idx);
        int v;
        v = idx * 7 + (idx >>> 8) + s * 85;
        return v[7:0];
    endfunction

    function automatic logic [10:0] fill_of(input int base, input int taken);
        int f;
        f = base - taken;
        return (f < 0) ? 11'd0 : f[10:0];
    endfunction

    // Source FIFO models: 1-cycle read latency, fill count drops as bytes are pulled.
    assign bus_a.src0_rnum = fill_of(base0, idx0 - mark0);
    assign bus_a.src1_rnum = fill_of(base1, idx1 - mark1);

    always @(posedge clk) begin
        if (bus_a.src0_rd_en) begin
            bus_a.src0_data <= src_byte(0, idx0);
            idx0 <= idx0 + 1;
        end
        if (bus_a.src1_rd_en) begin
            bus_a.src1_data <= src_byte(1, idx1);
            idx1 <= idx1 + 1;
        end
    end

    assign bus_b.src0_rnum = 11'd2047;
    assign bus_b.src1_rnum = 11'd0;
    assign bus_b.src0_data = 8'h5A;
    assign bus_b.src1_data = 8'h00;

    // Scoreboard: every accepted read pops one expected byte; an ignored pulse must yield 0.
    logic mon_took, mon_pulsed;
    exp_t mon_e;
    always @(posedge clk) begin
        mon_took   = rd_exp;
        mon_pulsed = bus_a.rd_en;
        #1;
        if (mon_took) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_underflow: rd_data %h with nothing expected", bus_a.rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus_a.rd_data !== mon_e.dat) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h expected %h (tag=%b)", bus_a.rd_data, mon_e.dat, mon_e.is_tag);
                end
                if (mon_e.is_tag) last_tag = bus_a.rd_data;
            end
        end else if (mon_pulsed) begin
            n_checks++;
            if (bus_a.rd_data !== 8'h00) begin
                n_errors++;
                $display("FAIL ignored_rd_data: got %h expected 00", bus_a.rd_data);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_a.rd_en = 1'b0;
        bus_b.rd_en = 1'b0;
        rd_exp = 1'b0;
        base0 = 0; base1 = 0; mark0 = idx0; mark1 = idx1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seq_m[0] = '0;
        seq_m[1] = '0;
        exp_q.delete();
    endtask

    task automatic run_packet(input logic gid, input int nreads, input bit gaps);
        bit   seen;
        logic e0, e1;
        seen = 1'b0;
        for (int spin = 0; spin < 50 && !seen; spin++) begin
            @(negedge clk);
            seen = bus_a.busy;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL grant_timeout: busy %b after 50 cycles, expected 1", bus_a.busy);
            return;
        end
        exp_q.push_back(exp_t'{is_tag: 1'b1, dat: {gid, seq_m[gid]}});
        for (int k = 0; k < DS - 1; k++)
            exp_q.push_back(exp_t'{is_tag: 1'b0, dat: src_byte(int'(gid), (gid ? idx1 : idx0) + k)});
        for (int i = 0; i < nreads; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                bus_a.rd_en = 1'b0;
                rd_exp = 1'b0;
                @(negedge clk);
            end
            n_checks++;
            if (bus_a.Rnum !== 11'(DS - i) || bus_a.busy !== 1'b1) begin
                n_errors++;
                $display("FAIL rnum_busy read %0d: Rnum %0d busy %b, expected Rnum %0d busy 1",
                         i, bus_a.Rnum, bus_a.busy, DS - i);
            end
            bus_a.rd_en = 1'b1;
            rd_exp = 1'b1;
            #1;
            e0 = (i > 0) && !gid;
            e1 = (i > 0) && gid;
            n_checks++;
            if (bus_a.src0_rd_en !== e0 || bus_a.src1_rd_en !== e1) begin
                n_errors++;
                $display("FAIL src_strobe read %0d: src0 %b src1 %b, expected src0 %b src1 %b",
                         i, bus_a.src0_rd_en, bus_a.src1_rd_en, e0, e1);
            end
            @(negedge clk);
        end
        bus_a.rd_en = 1'b0;
        rd_exp = 1'b0;
        if (nreads == DS) begin
            bus_a.rd_en = 1'b1;
            #1;
            n_checks++;
            if (bus_a.src0_rd_en !== 1'b0 || bus_a.src1_rd_en !== 1'b0 ||
                bus_a.Rnum !== 11'd0 || bus_a.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL drain: src0 %b src1 %b Rnum %0d busy %b, expected 0 0 0 0",
                         bus_a.src0_rd_en, bus_a.src1_rd_en, bus_a.Rnum, bus_a.busy);
            end
            @(negedge clk);
            bus_a.rd_en = 1'b0;
            seq_m[gid] = seq_m[gid] + 7'd1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_a.rd_en = 1'b1;
        rd_exp = 1'b0;
        #1;
        for (int r = 0; r < 2; r++) begin
            n_checks++;
            if (bus_a.src0_rd_en !== 1'b0 || bus_a.src1_rd_en !== 1'b0 || bus_a.Rnum !== 11'd0 ||
                bus_a.busy !== 1'b0 || bus_a.rd_data !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_state %0d: src0 %b src1 %b Rnum %0d busy %b rd_data %h, expected all 0",
                         r, bus_a.src0_rd_en, bus_a.src1_rd_en, bus_a.Rnum, bus_a.busy, bus_a.rd_data);
            end
            repeat (2) @(negedge clk);
        end
        bus_a.rd_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.Rnum !== 11'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy %b Rnum %0d, expected 0 0", bus_a.busy, bus_a.Rnum);
        end
    endtask

    task automatic test_single_src();
        int s1;
        apply_reset();
        s1 = idx1;
        base0 = 960;
        mark0 = idx0;
        last_tag = 8'hFF;
        run_packet(1'b0, DS, 1'b1);
        n_checks++;
        if (last_tag !== 8'h00) begin
            n_errors++;
            $display("FAIL single_tag: got %h expected 00", last_tag);
        end
        n_checks++;
        if (idx1 != s1) begin
            n_errors++;
            $display("FAIL single_src1_reads: got %0d reads expected 0", idx1 - s1);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus_a.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_regrant: busy %b expected 0", bus_a.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] tags [4];
        logic [7:0] want [4];
        want = '{8'h00, 8'h80, 8'h01, 8'h81};
        apply_reset();
        base0 = 1920; mark0 = idx0;
        base1 = 1920; mark1 = idx1;
        for (int p = 0; p < 4; p++) begin
            last_tag = 8'hFF;
            run_packet(p[0], DS, 1'b0);
            tags[p] = last_tag;
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (tags[p] !== want[p]) begin
                n_errors++;
                $display("FAIL rr_tag %0d: got %h expected %h", p, tags[p], want[p]);
            end
        end
    endtask

    task automatic test_threshold();
        apply_reset();
        base1 = 959;
        mark1 = idx1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.busy !== 1'b0 || bus_a.Rnum !== 11'd0) begin
                n_errors++;
                $display("FAIL below_threshold: busy %b Rnum %0d, expected 0 0", bus_a.busy, bus_a.Rnum);
            end
        end
        base1 = 960;
        mark1 = idx1;
        last_tag = 8'hFF;
        run_packet(1'b1, DS, 1'b1);
        n_checks++;
        if (last_tag !== 8'h80) begin
            n_errors++;
            $display("FAIL threshold_tag: got %h expected 80", last_tag);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        base0 = 1920;
        mark0 = idx0;
        run_packet(1'b0, 301, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.Rnum !== 11'd0 || bus_a.src0_rd_en !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_same: busy %b Rnum %0d src0 %b, expected 0 0 0",
                     bus_a.busy, bus_a.Rnum, bus_a.src0_rd_en);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.Rnum !== 11'd0 || bus_a.rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset_next: busy %b Rnum %0d rd_data %h, expected 0 0 00",
                     bus_a.busy, bus_a.Rnum, bus_a.rd_data);
        end
        exp_q.delete();
        seq_m[0] = '0;
        seq_m[1] = '0;
        last_tag = 8'hFF;
        run_packet(1'b0, DS, 1'b0);
        n_checks++;
        if (last_tag !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset_tag: got %h expected 00", last_tag);
        end
    endtask

    task automatic test_idle_pulses();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.rd_en = 1'b1;
            rd_exp = 1'b0;
            #1;
            n_checks++;
            if (bus_a.src0_rd_en !== 1'b0 || bus_a.src1_rd_en !== 1'b0 || bus_a.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_pulse %0d: src0 %b src1 %b busy %b, expected 0 0 0",
                         c, bus_a.src0_rd_en, bus_a.src1_rd_en, bus_a.busy);
            end
        end
        @(negedge clk);
        bus_a.rd_en = 1'b0;
    endtask

    task automatic test_seq_wrap();
        int         ntag;
        bit         prev_tag;
        logic [7:0] want;
        apply_reset();
        ntag = 0;
        prev_tag = 1'b0;
        bus_b.rd_en = 1'b1;
        for (int c = 0; c < 160 * DSB && ntag < 129; c++) begin
            @(negedge clk);
            if (prev_tag) begin
                want = {1'b0, 7'(ntag)};
                n_checks++;
                if (bus_b.rd_data !== want) begin
                    n_errors++;
                    $display("FAIL seq_tag %0d: got %h expected %h", ntag, bus_b.rd_data, want);
                end
                if (ntag == 128) begin
                    n_checks++;
                    if (bus_b.rd_data !== 8'h00) begin
                        n_errors++;
                        $display("FAIL seq_wrap: got %h expected 00", bus_b.rd_data);
                    end
                end
                ntag++;
            end
            prev_tag = bus_b.busy && (bus_b.Rnum == 11'(DSB));
        end
        bus_b.rd_en = 1'b0;
        n_checks++;
        if (ntag != 129) begin
            n_errors++;
            $display("FAIL seq_wrap_count: got %0d tags expected 129", ntag);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_exp = 1'b0;
        bus_a.rd_en = 1'b0;
        bus_b.rd_en = 1'b0;
        base0 = 0; base1 = 0; mark0 = 0; mark1 = 0;
        seq_m[0] = '0;
        seq_m[1] = '0;
        last_tag = 8'hFF;
        test_reset();
        test_single_src();
        test_round_robin();
        test_threshold();
        test_mid_reset();
        test_idle_pulses();
        test_seq_wrap();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/udp_src_arbiter.md
UDP_SRC_ARBITER -- requirements
Module: udp_src_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 16'd961: bytes per UDP payload; the sender reads exactly this many per packet; legal range 46..1500.
REQ-002 clk  in  1  single clock, the sender's transmit clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 src0_data  in  8  source-0 FIFO read data, valid one cycle after src0_rd_en.
REQ-005 src0_rd_en  out  1  source-0 FIFO read strobe.
REQ-006 src0_rnum  in  11  source-0 FIFO fill count in bytes.
REQ-007 src1_data, src1_rd_en, src1_rnum: same widths and meaning as source 0, for source 1.
REQ-008 rd_data  out  8  byte to sender, valid one cycle after rd_en.
REQ-009 rd_en  in  1  sender read strobe.
REQ-010 Rnum  out  11  virtual fill count advertised to sender.
REQ-011 busy  out  1  high while a packet is granted.

Function
REQ-012 States: IDLE, TAG, DATA, DRAIN.
REQ-013 Source n is eligible when srcn_rnum >= DATA_SIZE-1.
REQ-014 IDLE: neither eligible -> stay; one eligible -> grant it; both eligible -> grant the source not granted last (round-robin pointer, reset value selects source 0 first); move to TAG next cycle.
REQ-015 TAG: Rnum = DATA_SIZE; first rd_en is not forwarded to any source; next cycle rd_data = {grant id (1 bit), 7-bit per-source packet sequence}; state -> DATA on that rd_en.
REQ-016 DATA: each rd_en forwards combinationally to the granted source's rd_en only; the cycle after, rd_data = granted source's data; Rnum = DATA_SIZE minus reads taken so far.
REQ-017 Read counter 11 bits, counts every accepted rd_en including tag; on the DATA_SIZE-th rd_en -> DRAIN.
REQ-018 DRAIN: one cycle; rd_data still muxed from granted source; Rnum = 0; sequence of granted source increments (7-bit, wraps 127->0); round-robin pointer updates; -> IDLE.
REQ-019 IDLE and DRAIN: Rnum = 0, both srcn_rd_en = 0, rd_en ignored.
REQ-020 rd_en in any state never drives the non-granted source; rd_en after count complete is ignored.
REQ-021 rd_data mux select is registered with the read strobe so data/tag alignment matches a 1-cycle-latency FIFO.
REQ-022 Eligibility is sampled only in IDLE; later srcn_rnum changes do not affect a granted packet.
REQ-023 rd_data = 8'h00 when no byte was read in the previous cycle.
REQ-024 busy = 1 in TAG and DATA, 0 otherwise.

Reset
REQ-025 rst at any time, including mid-packet: state IDLE, counter 0, both sequences 0, pointer to source 0, Rnum 0, rd_data 0, busy 0, srcn_rd_en 0 in the same cycle rst is sampled.
REQ-026 Bytes already pulled from a source before a mid-packet reset are discarded; no replay.

Structure
REQ-027 State encoding, tag bit layout, and sequence width belong in the shared capture package.
REQ-028 A sub-module udp_rr_pick (2-way round-robin select from eligibility plus pointer) is natural; everything else stays flat.

Verification
REQ-029 Only src0_rnum = 960, DATA_SIZE 961: tag 8'h00 first, then 960 src0 bytes in order, src1_rd_en never high, Rnum 961->0.
REQ-030 Both sources full for 4 packets: grants 0,1,0,1; tags 8'h00,8'h80,8'h01,8'h81.
REQ-031 src1_rnum = 959: no grant, Rnum stays 0; raise to 960 -> tag 8'h80 and 960 src1 bytes.
REQ-032 128 src0 packets: 129th tag is 8'h00 (wrap).
REQ-033 rst asserted after 300 DATA reads: next cycle Rnum 0, busy 0; following packet tag sequence 0.
REQ-034 Extra rd_en pulses in IDLE and DRAIN: no srcn_rd_en asserted, rd_data 8'h00.
